// File: rtl/ram_master_port.sv
// ram_master_port: processor-side initiator for the sdram_block RAM request
// interface. Turns single CPU loads/stores into write/read FIFO pushes, waits
// for read data, pops it and hands it back to the CPU. One read in flight at a
// time, writes are posted. A read that never answers is abandoned after
// TIMEOUT cycles; its late data is later popped and thrown away (DRAIN).
module ram_master_port #(
  parameter int TIMEOUT = 1024,
  parameter int STALE_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [15:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic        cpu_err,
  output logic [23:0] ram_addr,
  output logic [15:0] ram_wr_data,
  output logic        ram_wr_en,
  output logic        ram_rd_en,
  input  logic        ram_busy,
  input  logic        ram_rd_ready,
  input  logic [15:0] ram_rd_data,
  output logic        ram_rd_ack
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    RD_WAIT = 3'd2,
    RD_ACK  = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t               state_r;
  logic                 we_r;
  logic [CNT_W-1:0]     tcnt_r;
  logic [STALE_W-1:0]   stale_r;
  logic                 stale_pending_s;

  // Late data from an abandoned read sits at the FIFO head: it must be
  // drained before any new request is accepted, otherwise the next read
  // would pick up the wrong word.
  assign stale_pending_s = (stale_r != {STALE_W{1'b0}}) && ram_rd_ready;

  // Accept is a same-cycle handshake so a request costs no extra cycle.
  assign cpu_ready = (state_r == IDLE) && !stale_pending_s;

  // Pushes are gated directly by ram_busy so a push can never land on a
  // full FIFO, even if busy rises in the very cycle the push is due.
  assign ram_wr_en = (state_r == ISSUE) && we_r && !ram_busy;
  assign ram_rd_en = (state_r == ISSUE) && !we_r && !ram_busy;

  // Request sequencer: state, request latch, timeout/stale counters and the
  // registered CPU response / FIFO pop pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      we_r        <= 1'b0;
      tcnt_r      <= {CNT_W{1'b0}};
      stale_r     <= {STALE_W{1'b0}};
      cpu_rdata   <= 16'h0000;
      cpu_rvalid  <= 1'b0;
      cpu_err     <= 1'b0;
      ram_addr    <= 24'h000000;
      ram_wr_data <= 16'h0000;
      ram_rd_ack  <= 1'b0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      cpu_rvalid <= 1'b0;
      cpu_err    <= 1'b0;
      ram_rd_ack <= 1'b0;
      case (state_r)
        IDLE: begin
          if (stale_pending_s) begin
            state_r <= DRAIN;
          end else if (cpu_req) begin
            ram_addr    <= cpu_addr;
            ram_wr_data <= cpu_wdata;
            we_r        <= cpu_we;
            state_r     <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (!ram_busy) begin
            if (we_r) begin
              state_r <= IDLE;
            end else begin
              tcnt_r  <= {CNT_W{1'b0}};
              state_r <= RD_WAIT;
            end
          end else begin
            state_r <= ISSUE;
          end
        end
        RD_WAIT: begin
          tcnt_r <= tcnt_r + CNT_W'(1);
          // Arrival is tested first so data on the last allowed cycle still
          // completes normally and does not count as stale.
          if (ram_rd_ready) begin
            cpu_rdata  <= ram_rd_data;
            cpu_rvalid <= 1'b1;
            ram_rd_ack <= 1'b1;
            state_r    <= RD_ACK;
          end else if (tcnt_r == TO_LAST) begin
            cpu_rdata  <= 16'h0000;
            cpu_rvalid <= 1'b1;
            cpu_err    <= 1'b1;
            if (stale_r != {STALE_W{1'b1}}) begin
              stale_r <= stale_r + STALE_W'(1);
            end else begin
              stale_r <= stale_r;
            end
            state_r <= IDLE;
          end else begin
            state_r <= RD_WAIT;
          end
        end
        RD_ACK: begin
          // Settle cycle: lets the FIFO empty flag catch up with the pop.
          state_r <= IDLE;
        end
        DRAIN: begin
          ram_rd_ack <= 1'b1;
          stale_r    <= stale_r - STALE_W'(1);
          state_r    <= RD_ACK;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
